// File: rtl/nb_updown_counter_if.sv
// nb_updown_counter_if: groups the control, load and status signals of
// nb_updown_counter. The master side (system/testbench) drives ei/up/ld/d;
// the slave side (the counter) returns q/eu/zero.
interface nb_updown_counter_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic           ei;
  logic           up;
  logic           ld;
  logic [N*W-1:0] d;
  logic [N*W-1:0] q;
  logic           eu;
  logic           zero;

  modport master (output ei, up, ld, d, input q, eu, zero);
  modport slave  (input ei, up, ld, d, output q, eu, zero);
endinterface

// File: rtl/nb_updown_counter.sv
// nb_updown_counter: N-digit, base-B up/down counter with synchronous
// parallel load (loaded digits clamped to B-1), combinational carry/borrow
// out (eu) for cascading, and a zero decode of the count.
// Optional build macro UDC_SATURATE_EN: when defined, a step from the
// all-terminal state holds the count instead of wrapping (eu still flags it).
module nb_updown_counter #(
  parameter int N = 4,
  parameter int B = 10,
  parameter int W = 4
) (
  input  logic                clock,
  input  logic                reset_,
  nb_updown_counter_if.slave  bus
);

  localparam logic [W-1:0] DIGIT_MAX = W'(B - 1);
  localparam logic [W:0]   BASE      = (W + 1)'(B);

  logic [N*W-1:0] r_q;
  logic [N*W-1:0] w_q_next;
  logic [N-1:0]   w_term;
  // w_low_term[i]: every digit below i is terminal (digit 0 has none below)
  logic [N:0]     w_low_term;
  logic           w_all_term;
  logic           w_step;

  assign w_low_term[0] = 1'b1;
  assign w_all_term    = w_low_term[N];

`ifdef UDC_SATURATE_EN
  // Saturating build: stepping out of the all-terminal state is suppressed.
  assign w_step = bus.ei & ~w_all_term;
`else
  assign w_step = bus.ei;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_digit
      logic [W-1:0] w_digit;
      logic [W-1:0] w_load;
      logic [W-1:0] w_stepped;

      assign w_digit = r_q[gi*W +: W];

      // Out-of-range load digits are clamped so q never holds a digit >= B.
      assign w_load = ({1'b0, bus.d[gi*W +: W]} >= BASE) ? DIGIT_MAX
                                                         : bus.d[gi*W +: W];

      assign w_term[gi]       = bus.up ? (w_digit == DIGIT_MAX) : (w_digit == '0);
      assign w_low_term[gi+1] = w_low_term[gi] & w_term[gi];

      // Single-digit step with wrap: up B-1 -> 0, down 0 -> B-1.
      assign w_stepped = bus.up ? (w_term[gi] ? '0 : w_digit + W'(1))
                                : (w_term[gi] ? DIGIT_MAX : w_digit - W'(1));

      // Load beats counting; a digit steps only when all lower digits roll.
      assign w_q_next[gi*W +: W] = bus.ld                      ? w_load    :
                                   (w_step & w_low_term[gi])   ? w_stepped :
                                                                 w_digit;
    end
  endgenerate

  // Count register: asynchronous clear, otherwise load/step/hold.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign bus.q    = r_q;
  assign bus.eu   = bus.ei & ~bus.ld & w_all_term;
  assign bus.zero = (r_q == '0);

endmodule

// File: tb/tb_nb_updown_counter.sv
// tb_nb_updown_counter: directed checks of nb_updown_counter (N=4, B=10 BCD
// instance plus an N=3, B=2, W=1 instance). Expected values are written by
// hand as hex-coded digits. Honours UDC_SATURATE_EN for wrap expectations.
module tb_nb_updown_counter;

  logic clock;
  logic reset_;
  int   n_checks;
  int   n_fail;

  nb_updown_counter_if #(.N(4), .W(4)) b_if ();
  nb_updown_counter_if #(.N(3), .W(1)) c_if ();

  nb_updown_counter #(.N(4), .B(10), .W(4)) u_bcd (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (b_if)
  );

  nb_updown_counter #(.N(3), .B(2), .W(1)) u_bin (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (c_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("assertion %s", tag);
    end
  endtask

  // One full clock: the rising edge acts, then sample on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load_bcd(input logic [15:0] val);
    b_if.ld = 1'b1;
    b_if.ei = 1'b0;
    b_if.d  = val;
    tick();
    b_if.ld = 1'b0;
    b_if.d  = '0;
  endtask

  logic [4:0]  dir_seq;
  logic [15:0] exp_seq [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_   = 1'b1;
    b_if.ei = 1'b0; b_if.up = 1'b0; b_if.ld = 1'b0; b_if.d = '0;
    c_if.ei = 1'b0; c_if.up = 1'b0; c_if.ld = 1'b0; c_if.d = '0;

    // 1. Asynchronous reset between edges, then 12 up-steps.
    #2 reset_ = 1'b0;
    #1;
    chk("rst_q", b_if.q, 16'h0000);
    chk("rst_zero", {15'd0, b_if.zero}, 16'h0001);
    chk("rst_eu", {15'd0, b_if.eu}, 16'h0000);
    chk("rst_bin_q", {13'd0, c_if.q}, 16'h0000);
    #10 reset_ = 1'b1;
    @(negedge clock);
    b_if.ei = 1'b1; b_if.up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("count12_eu", {15'd0, b_if.eu}, 16'h0000);
      tick();
    end
    chk("count12_q", b_if.q, 16'h0012);
    chk("count12_zero", {15'd0, b_if.zero}, 16'h0000);
    b_if.ei = 1'b0;
    $display("step1: q=%h", b_if.q);

    // 2. Ripple 0999 -> 1000.
    load_bcd(16'h0999);
    chk("ld0999_q", b_if.q, 16'h0999);
    b_if.ei = 1'b1; b_if.up = 1'b1;
    #1;
    chk("ripple_eu", {15'd0, b_if.eu}, 16'h0000);
    tick();
    b_if.ei = 1'b0;
    chk("ripple_q", b_if.q, 16'h1000);
    $display("step2: q=%h", b_if.q);

    // 3. Down from 0000: borrow out, wrap (or hold when saturating).
    load_bcd(16'h0000);
    b_if.ei = 1'b1; b_if.up = 1'b0;
    #1;
    chk("under_eu", {15'd0, b_if.eu}, 16'h0001);
    tick();
`ifdef UDC_SATURATE_EN
    chk("under_eu_hold", {15'd0, b_if.eu}, 16'h0001);
    b_if.ei = 1'b0;
    chk("under_q", b_if.q, 16'h0000);
    chk("under_zero", {15'd0, b_if.zero}, 16'h0001);
`else
    b_if.ei = 1'b0;
    chk("under_q", b_if.q, 16'h9999);
    chk("under_zero", {15'd0, b_if.zero}, 16'h0000);
`endif
    $display("step3: q=%h", b_if.q);

    // 3b. Up from 9999: carry out, wrap (or hold when saturating).
    load_bcd(16'h9999);
    b_if.ei = 1'b1; b_if.up = 1'b1;
    #1;
    chk("over_eu", {15'd0, b_if.eu}, 16'h0001);
    tick();
    b_if.ei = 1'b0;
`ifdef UDC_SATURATE_EN
    chk("over_q", b_if.q, 16'h9999);
`else
    chk("over_q", b_if.q, 16'h0000);
`endif
    $display("step3b: q=%h", b_if.q);

    // 4. Load clamp and load-over-count priority.
    b_if.ld = 1'b1; b_if.ei = 1'b1; b_if.up = 1'b1; b_if.d = 16'h12F9;
    #1;
    chk("ldpri_eu", {15'd0, b_if.eu}, 16'h0000);
    tick();
    b_if.ld = 1'b0; b_if.ei = 1'b0; b_if.d = '0;
    chk("clamp_q", b_if.q, 16'h1299);
    $display("step4: q=%h", b_if.q);

    // 5. Direction changes every edge.
    load_bcd(16'h0500);
    dir_seq = 5'b00011;  // applied LSB first: up, up, down, down, down
    exp_seq[0] = 16'h0501; exp_seq[1] = 16'h0502; exp_seq[2] = 16'h0501;
    exp_seq[3] = 16'h0500; exp_seq[4] = 16'h0499;
    b_if.ei = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_if.up = dir_seq[i];
      tick();
      chk("dir_q", b_if.q, exp_seq[i]);
      $display("step5[%0d]: up=%0b q=%h", i, dir_seq[i], b_if.q);
    end
    b_if.ei = 1'b0;

    // 6. Reset in the middle of counting, then resume.
    load_bcd(16'h0777);
    b_if.ei = 1'b1; b_if.up = 1'b1;
    tick();
    chk("pre_rst_q", b_if.q, 16'h0778);
    #2 reset_ = 1'b0;
    #1;
    chk("midrst_q", b_if.q, 16'h0000);
    #1 reset_ = 1'b1;
    tick();
    b_if.ei = 1'b0;
    chk("resume_q", b_if.q, 16'h0001);
    $display("step6: q=%h", b_if.q);

    // 6b. Binary 3-digit instance: 111 up wraps to 000, 000 down.
    c_if.ld = 1'b1; c_if.d = 3'b111;
    tick();
    c_if.ld = 1'b0;
    chk("bin_ld_q", {13'd0, c_if.q}, 16'h0007);
    c_if.ei = 1'b1; c_if.up = 1'b1;
    #1;
    chk("bin_up_eu", {15'd0, c_if.eu}, 16'h0001);
    tick();
`ifdef UDC_SATURATE_EN
    chk("bin_up_q", {13'd0, c_if.q}, 16'h0007);
    c_if.ei = 1'b0;
    c_if.ld = 1'b1; c_if.d = 3'b000;
    tick();
    c_if.ld = 1'b0; c_if.ei = 1'b1;
`else
    chk("bin_up_q", {13'd0, c_if.q}, 16'h0000);
    chk("bin_zero", {15'd0, c_if.zero}, 16'h0001);
`endif
    c_if.up = 1'b0;
    #1;
    chk("bin_dn_eu", {15'd0, c_if.eu}, 16'h0001);
    tick();
    c_if.ei = 1'b0;
`ifdef UDC_SATURATE_EN
    chk("bin_dn_q", {13'd0, c_if.q}, 16'h0000);
`else
    chk("bin_dn_q", {13'd0, c_if.q}, 16'h0007);
`endif
    $display("step6b: bin q=%b", c_if.q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nb_updown_counter.md
Name: nb_updown_counter

Overview:
- Parametrised N-digit, base-B up/down counter with synchronous parallel load.
- Generalises the fixed 4-digit base-2 down counter: digit count, base and direction are selectable.
- Uses the same enable-in/enable-out chaining: ei in, eu out, so instances cascade into wider counters.
- Used for BCD timers, prescalers and event counters in the lab designs.

Parameters:
N, 4, number of digits (>= 1)
B, 10, base of every digit (2..16)
W, 4, bits per digit; must satisfy 2^W >= B

Ports:
clock  input  1  system clock, rising edge
reset_  input  1  asynchronous active-low reset
ei  input  1  count enable; one step per clock while high
up  input  1  direction: 1 = count up, 0 = count down
ld  input  1  synchronous parallel load strobe
d  input  N*W  load value; digit i in d[i*W +: W], digit 0 least significant
q  output  N*W  current count; same digit layout as d
eu  output  1  carry/borrow out; enables the next cascaded counter
zero  output  1  high when every digit of q is 0

Behaviour:
- Clock and reset: one clock (clock); reset_ is asynchronous and active-low. While reset_=0, q=0 immediately, independent of clock. Consequently zero=1, and eu=0 unless ei=1 with up=0.
- Priority per rising edge, highest first: ld, then ei, then hold.
- ld=1: each digit i of q takes d digit i. A digit value >= B is clamped to B-1; the other digits load unchanged. ei is ignored in a load cycle.
- ld=0, ei=1: the whole counter steps by 1 in the direction given by up. up is sampled on the same edge, so it may change on any cycle.
- Digit chaining:
  - Digit 0 steps whenever ei=1.
  - Digit i>0 steps when ei=1 and all lower digits are terminal.
  - Terminal means B-1 when counting up and 0 when counting down.
- Wrap-around per digit: up B-1 -> 0; down 0 -> B-1.
- Full wrap: all digits terminal at the step -> q wraps to all-0 (up) or all-(B-1) (down).
- eu = ei & ~ld & (all digits terminal for the current up). It is combinational, so ei->eu is a same-cycle path for cascading. eu=0 in a load cycle.
- zero: combinational decode of q. It is independent of ei and ld.
- Latency: q reflects a load or step one clock after the sampling edge.
- Digit values >= B are unreachable after reset, because loads clamp.
- Reset mid-operation (including during ld): q=0 at once. Counting resumes on the first edge after reset_ rises.

Optional Feature:
- Macro: UDC_SATURATE_EN.
- Defined: when ei=1, ld=0 and all digits are terminal, q holds instead of wrapping. eu is still asserted that cycle to flag the overflow/underflow attempt. Counting in the opposite direction proceeds normally.
- Not defined: full wrap-around as described in Behaviour.
- The ld, zero and reset behaviour is identical in both builds.

Test Plan:
1. Defaults N=4, B=10. Pulse reset_ low asynchronously between edges -> q=0000 at once and zero=1. Then ei=1, up=1 for 12 clocks -> q=0012, eu never 1.
2. ld=1 with d=0999, then ei=1, up=1 for one clock -> eu=0 in that cycle; q=1000 next cycle.
3. q=0000, ei=1, up=0 -> eu=1 combinationally that cycle; next edge q=9999 and zero=0. With UDC_SATURATE_EN: q stays 0000 and eu=1.
4. Load clamp and priority: ld=1, ei=1, up=1 with d=12F9 (hex digits) -> q=1299 next edge (digit F clamped to 9, no increment), eu=0 during the load cycle.
5. Direction change: q=0500, ei=1 with up=1,1,0,0,0 on five edges -> q=0501, 0502, 0501, 0500, 0499.
6. Reset mid-run: q=0777 counting up; assert reset_=0 for half a cycle -> q=0000 immediately. After release, one ei edge -> q=0001. Also run N=3, B=2, W=1 from 111 up -> eu=1, q=000.
